bus_arbiter: RTL
================

# bus_arbiter

Round-robin arbiter that shares the single RAM port among the two dcaches and two icaches of the dual-core system. It sits in front of the bus/coherence controller and decides which requester owns the bus. It holds a grant for the full transaction, counting RAM `ACCESS` beats: 2 beats per data block, 1 beat per instruction word. Data requests have priority over instruction fetches, round-robin within each class. An age counter keeps instruction fetches from starving.

## Interface
Parameters:
- `DBEATS`, default 2: RAM `ACCESS` beats per dcache transaction (block fill/writeback/snoop supply).
- `IBEATS`, default 1: RAM `ACCESS` beats per icache transaction.
- `IWAIT_MAX`, default 8: cycles a pending, ungranted icache request waits before it overrides data priority.

Ports:
- `CLK`, in, 1: system clock, rising edge.
- `nRST`, in, 1: reset, asynchronous, active-low.
- `dreq`, in, 2: per-core dcache request (`dREN|dWEN|cctrans`), level, held until done.
- `ireq`, in, 2: per-core icache request (`iREN`), level.
- `ramstate`, in, `ramstate_t`: RAM status; a beat completes on a cycle with `ACCESS`.
- `grant`, out, 4: one-hot owner `{i1,i0,d1,d0}`, registered; 0 = none.
- `busy`, out, 1: a grant is active.
- `beat`, out, `$clog2(max(DBEATS,IBEATS))` bits: index of the current beat within the transaction.
- `last_beat`, out, 1: current beat is the final one (`beat == N-1`).

## Operation
- Two states: `ARB_IDLE` and `ARB_BUSY`.
- Reset values: state `ARB_IDLE`, `grant = 0`, `busy = 0`, `beat = 0`, `last_beat = 0`, `dptr = 0` (d0 first), `iptr = 0` (i0 first), ages 0.

In `ARB_IDLE`, if any request is asserted, pick a winner, register it into `grant` and go to `ARB_BUSY`:
- An icache age equal to `IWAIT_MAX` wins. If both are aged, the tie is broken by `iptr`.
- Else, any `dreq` wins. If both are asserted, `dptr` selects.
- Else, any `ireq` wins. If both are asserted, `iptr` selects.

In `ARB_BUSY`:
- `N = DBEATS` for a d-grant, `IBEATS` for an i-grant.
- `beat` increments on each `ACCESS`.
- On `ACCESS` while `last_beat`, go to `ARB_IDLE`, clear `grant` and `beat`, and set the class pointer to the other core (the winner gets lowest priority next).
- If the granted request drops before completion, go to `ARB_IDLE` next cycle, clear `grant` and `beat`, and advance the pointer as on completion.
- Aborts are not reported.

Age counters, one per icache, saturating at `IWAIT_MAX`:
- Increment each cycle its `ireq` is high and it is not granted.
- Clear on grant to that icache, or when its `ireq` is low.

Requests arriving while `ARB_BUSY` are not granted until the next `ARB_IDLE` cycle. There is no preemption.

## Timing
- Arbitration latency: request seen in `ARB_IDLE` at cycle t, `grant` and `busy` high at t+1.
- Minimum gap: one `ARB_IDLE` cycle between consecutive grants, including back-to-back requests from the same requester.
- Release: final `ACCESS` at cycle t, `grant = 0` at t+1, next grant at t+2.
- `beat` and `last_beat` are registered and valid the cycle `grant` rises.
- `ramstate` values other than `ACCESS` (`BUSY`, `FREE`, `ERROR`) stall the beat count. The arbiter has no timeout.
- Asynchronous reset mid-transaction forces all outputs to reset values immediately. The pointers and ages also reset.

## Structure
- `arb_state_t` (`ARB_IDLE`, `ARB_BUSY`) and the grant-bit index constants (`GNT_D0 = 0`, `GNT_D1 = 1`, `GNT_I0 = 2`, `GNT_I1 = 3`) belong in `diaosi_types_pkg`.
- `ramstate_t` comes from `cpu_types_pkg`.
- One sub-module is natural: `rr_pick2`, a combinational 2-way round-robin picker (`req[1:0]`, `ptr` → one-hot `pick`). It is instantiated three times: data, instruction, and aged-instruction.

## Test plan
- Reset, then `dreq = 2'b11` and `ACCESS` every cycle → `grant = 0001` for 2 beats, 1 idle cycle, then `0010` for 2 beats.
- `dreq[0]` and `ireq[1]` asserted together → d0 granted first (2 beats), then `grant = 1000` for 1 beat.
- `dreq[0]` held continuously re-requesting and `ireq[0]` held, with `IWAIT_MAX = 8` → `grant = 0100` no later than the first `ARB_IDLE` after `ireq[0]` has waited 8 cycles.
- d1 granted, `ramstate = BUSY` for 5 cycles, then `ACCESS` ×2 → `beat` stays 0 for 5 cycles, `last_beat` rises on beat 1, release after the second `ACCESS`.
- d0 granted, `dreq[0]` dropped after beat 0 → `grant = 0` next cycle, `dptr` = 1.
- `nRST` asserted mid-beat while d1 is granted → `grant`, `busy`, `beat` = 0 asynchronously. After release with `dreq = 2'b11`, d0 is granted first.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types; only the RAM status encoding is needed by the bus arbiter.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// Bus arbiter types: FSM state, one-hot grant bit positions and beat-counter sizing.
package diaosi_types_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int unsigned GNT_D0 = 0;
    localparam int unsigned GNT_D1 = 1;
    localparam int unsigned GNT_I0 = 2;
    localparam int unsigned GNT_I1 = 3;

    // Beat index width; never narrower than one bit so single-beat configs still elaborate.
    function automatic int unsigned beat_w(input int unsigned dbeats, input int unsigned ibeats);
        int unsigned m;
        m = (dbeats > ibeats) ? dbeats : ibeats;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: ptr names the requester preferred on a tie.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] pick
);

    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner selection for the shared RAM port: dcaches over icaches, with icache aging.
module bus_arbiter
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;
#(
    parameter  int unsigned DBEATS    = 2,
    parameter  int unsigned IBEATS    = 1,
    parameter  int unsigned IWAIT_MAX = 8,
    localparam int unsigned BW        = beat_w(DBEATS, IBEATS)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic [1:0]    dreq,
    input  logic [1:0]    ireq,
    input  ramstate_t     ramstate,
    output logic [3:0]    grant,
    output logic          busy,
    output logic [BW-1:0] beat,
    output logic          last_beat
);

    localparam int unsigned AW = $clog2(IWAIT_MAX + 1);

    arb_state_t           state, state_d;
    logic [3:0]           grant_d;
    logic                 busy_d;
    logic [BW-1:0]        beat_d;
    logic                 last_d;
    logic                 dptr, dptr_d;
    logic                 iptr, iptr_d;
    logic [1:0][AW-1:0]   age, age_d;
    logic [1:0]           aged;
    logic [1:0]           pick_d, pick_i, pick_a;
    logic                 held;
    logic                 done;
    logic [BW-1:0]        last_idx;

    rr_pick2 u_pick_data (.req(dreq), .ptr(dptr), .pick(pick_d));
    rr_pick2 u_pick_inst (.req(ireq), .ptr(iptr), .pick(pick_i));
    rr_pick2 u_pick_aged (.req(aged), .ptr(iptr), .pick(pick_a));

    assign aged[0]  = ireq[0] && (age[0] == AW'(IWAIT_MAX));
    assign aged[1]  = ireq[1] && (age[1] == AW'(IWAIT_MAX));
    assign held     = |(grant & {ireq, dreq});
    assign done     = !held || ((ramstate == ACCESS) && last_beat);
    assign last_idx = (grant[GNT_D0] || grant[GNT_D1]) ? BW'(DBEATS - 1) : BW'(IBEATS - 1);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= ARB_IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            beat      <= '0;
            last_beat <= 1'b0;
            dptr      <= 1'b0;
            iptr      <= 1'b0;
            age       <= '0;
        end else begin
            state     <= state_d;
            grant     <= grant_d;
            busy      <= busy_d;
            beat      <= beat_d;
            last_beat <= last_d;
            dptr      <= dptr_d;
            iptr      <= iptr_d;
            age       <= age_d;
        end
    end

    always_comb begin
        state_d = state;
        grant_d = grant;
        busy_d  = busy;
        beat_d  = beat;
        last_d  = last_beat;
        dptr_d  = dptr;
        iptr_d  = iptr;
        unique case (state)
            ARB_IDLE: begin
                if (|{ireq, dreq}) begin
                    if (|aged) begin
                        grant_d = {pick_a, 2'b00};
                    end else if (|dreq) begin
                        grant_d = {2'b00, pick_d};
                    end else begin
                        grant_d = {pick_i, 2'b00};
                    end
                    state_d = ARB_BUSY;
                    busy_d  = 1'b1;
                    beat_d  = '0;
                    last_d  = (|grant_d[1:0]) ? (DBEATS == 1) : (IBEATS == 1);
                end
            end
            ARB_BUSY: begin
                // Completion and abort both release and hand priority to the other core.
                if (done) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    beat_d  = '0;
                    last_d  = 1'b0;
                    if (grant[GNT_D0]) dptr_d = 1'b1;
                    if (grant[GNT_D1]) dptr_d = 1'b0;
                    if (grant[GNT_I0]) iptr_d = 1'b1;
                    if (grant[GNT_I1]) iptr_d = 1'b0;
                end else if (ramstate == ACCESS) begin
                    beat_d = beat + BW'(1);
                    last_d = (beat_d == last_idx);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Per-icache wait age, saturating so an aged request keeps its override until served.
    always_comb begin
        age_d = age;
        for (int k = 0; k < 2; k++) begin
            if (!ireq[k] || grant[GNT_I0 + k] || grant_d[GNT_I0 + k]) begin
                age_d[k] = '0;
            end else if (age[k] != AW'(IWAIT_MAX)) begin
                age_d[k] = age[k] + AW'(1);
            end
        end
    end

endmodule
